// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             ex_valid;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_pc_sel;
    logic             ex_md_op;
    logic             md_done;

    logic             pc_hold;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_ex_hold;
    logic             id_ex_bubble;
    logic             ex_mem_bubble;
    logic             md_start;
    logic             md_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_valid, ex_rd, ex_is_load, ex_pc_sel, ex_md_op, md_done,
        input  pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble,
        input  ex_mem_bubble, md_start, md_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_valid, ex_rd, ex_is_load, ex_pc_sel, ex_md_op, md_done,
        output pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble,
        output ex_mem_bubble, md_start, md_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: redirect > mul/div wait > load-use bubbles.
// Controls are combinational from state and inputs; the holds themselves are the pipeline backpressure.
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT   = 1,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input logic               sys_clk,
    input logic               sys_rst,
    pipe_hazard_ctrl_if.slave hz_if
);
    localparam int LD_W = 3;
    localparam int MD_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        MDWAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [MD_W-1:0] md_cnt_q, md_cnt_d;
    logic            timeout_q;
    logic            timeout_set;
    logic [CNT_W-1:0] stall_q;

    logic hz;
    logic pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_hold_c;
    logic id_ex_bubble_c, ex_mem_bubble_c, md_start_c;

    assign hz = hz_if.ex_valid && hz_if.ex_is_load && (hz_if.ex_rd != 5'd0) &&
                ((hz_if.id_rs1_used && (hz_if.id_rs1 == hz_if.ex_rd)) ||
                 (hz_if.id_rs2_used && (hz_if.id_rs2 == hz_if.ex_rd)));

    always_comb begin
        state_d         = state_q;
        ld_cnt_d        = ld_cnt_q;
        md_cnt_d        = md_cnt_q;
        timeout_set     = 1'b0;
        pc_hold_c       = 1'b0;
        if_id_hold_c    = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_hold_c    = 1'b0;
        id_ex_bubble_c  = 1'b0;
        ex_mem_bubble_c = 1'b0;
        md_start_c      = 1'b0;
        case (state_q)
            RUN: begin
                if (hz_if.ex_valid && hz_if.ex_pc_sel) begin
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                end else if (hz_if.ex_valid && hz_if.ex_md_op) begin
                    md_start_c      = 1'b1;
                    pc_hold_c       = 1'b1;
                    if_id_hold_c    = 1'b1;
                    id_ex_hold_c    = 1'b1;
                    ex_mem_bubble_c = 1'b1;
                    md_cnt_d        = '0;
                    state_d         = MDWAIT;
                end else if (hz) begin
                    pc_hold_c      = 1'b1;
                    if_id_hold_c   = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    // A single-cycle load latency clears itself as the load moves on.
                    if (LOAD_LAT > 1) begin
                        ld_cnt_d = LD_W'(LOAD_LAT - 1);
                        state_d  = LDUSE;
                    end
                end
            end
            LDUSE: begin
                pc_hold_c      = 1'b1;
                if_id_hold_c   = 1'b1;
                id_ex_bubble_c = 1'b1;
                ld_cnt_d       = ld_cnt_q - LD_W'(1);
                if (ld_cnt_q == LD_W'(1)) begin
                    state_d = RUN;
                end
            end
            MDWAIT: begin
                pc_hold_c       = 1'b1;
                if_id_hold_c    = 1'b1;
                id_ex_hold_c    = 1'b1;
                ex_mem_bubble_c = 1'b1;
                md_cnt_d        = md_cnt_q + MD_W'(1);
                if (hz_if.md_done) begin
                    state_d = RUN;
                end else if (md_cnt_q == MD_W'(MD_TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_d     = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q   <= RUN;
            ld_cnt_q  <= '0;
            md_cnt_q  <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            md_cnt_q <= md_cnt_d;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if (pc_hold_c && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    // Inputs may look like a redirect during reset; keep every control quiet then.
    assign hz_if.pc_hold       = sys_rst & pc_hold_c;
    assign hz_if.if_id_hold    = sys_rst & if_id_hold_c;
    assign hz_if.if_id_flush   = sys_rst & if_id_flush_c;
    assign hz_if.id_ex_hold    = sys_rst & id_ex_hold_c;
    assign hz_if.id_ex_bubble  = sys_rst & id_ex_bubble_c;
    assign hz_if.ex_mem_bubble = sys_rst & ex_mem_bubble_c;
    assign hz_if.md_start      = sys_rst & md_start_c;
    assign hz_if.md_timeout    = timeout_q;
    assign hz_if.stall_cycles  = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Two sequencer instances (default and short-timeout/narrow-counter) driven by shared stimulus
// and compared each cycle against a behavioural pipeline-stall model.
module tb_pipe_hazard_ctrl;
    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_pc_sel, ex_md_op, md_done;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_hazard_ctrl_if #(.CNT_W(32)) ia ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  ib ();

    pipe_hazard_ctrl #(.LOAD_LAT(1), .MD_TIMEOUT(64), .CNT_W(32)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hz_if(ia.slave));
    pipe_hazard_ctrl #(.LOAD_LAT(3), .MD_TIMEOUT(8), .CNT_W(4)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hz_if(ib.slave));

    always #5 sys_clk = ~sys_clk;

    assign ia.id_rs1 = id_rs1;           assign ib.id_rs1 = id_rs1;
    assign ia.id_rs2 = id_rs2;           assign ib.id_rs2 = id_rs2;
    assign ia.id_rs1_used = id_rs1_used; assign ib.id_rs1_used = id_rs1_used;
    assign ia.id_rs2_used = id_rs2_used; assign ib.id_rs2_used = id_rs2_used;
    assign ia.ex_valid = ex_valid;       assign ib.ex_valid = ex_valid;
    assign ia.ex_rd = ex_rd;             assign ib.ex_rd = ex_rd;
    assign ia.ex_is_load = ex_is_load;   assign ib.ex_is_load = ex_is_load;
    assign ia.ex_pc_sel = ex_pc_sel;     assign ib.ex_pc_sel = ex_pc_sel;
    assign ia.ex_md_op = ex_md_op;       assign ib.ex_md_op = ex_md_op;
    assign ia.md_done = md_done;         assign ib.md_done = md_done;

    // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_bubble, md_start}
    logic [6:0]  got_ctrl [2];
    logic [31:0] got_stall [2];
    logic        got_to [2];
    assign got_ctrl[0] = {ia.pc_hold, ia.if_id_hold, ia.if_id_flush, ia.id_ex_hold,
                          ia.id_ex_bubble, ia.ex_mem_bubble, ia.md_start};
    assign got_ctrl[1] = {ib.pc_hold, ib.if_id_hold, ib.if_id_flush, ib.id_ex_hold,
                          ib.id_ex_bubble, ib.ex_mem_bubble, ib.md_start};
    assign got_stall[0] = ia.stall_cycles;
    assign got_stall[1] = 32'(ib.stall_cycles);
    assign got_to[0]    = ia.md_timeout;
    assign got_to[1]    = ib.md_timeout;

    // Reference model: bubbles still owed, mul/div cycles spent, sticky flag, hold-cycle tally.
    int     load_lat [2]  = '{1, 3};
    int     md_limit [2]  = '{64, 8};
    longint cnt_max  [2]  = '{64'hFFFF_FFFF, 64'd15};
    int     m_bubbles [2];
    bit     m_md_busy [2];
    int     m_md_spent [2];
    bit     m_to [2];
    longint m_cnt [2];
    bit     prev_start [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_bubbles[i] = 0; m_md_busy[i] = 0; m_md_spent[i] = 0;
            m_to[i] = 0; m_cnt[i] = 0; prev_start[i] = 0;
        end
    endtask

    task automatic model_step(input int i, output logic [6:0] c);
        bit uses_load;
        c = 7'b0;
        if (!sys_rst) begin
            m_bubbles[i] = 0; m_md_busy[i] = 0; m_md_spent[i] = 0;
            m_to[i] = 0; m_cnt[i] = 0;
            return;
        end
        uses_load = ex_valid && ex_is_load && (ex_rd != 0) &&
                    ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        if (m_bubbles[i] > 0) begin
            c = 7'b1100100;
            m_bubbles[i]--;
        end else if (m_md_busy[i]) begin
            c = 7'b1101010;
            if (md_done) m_md_busy[i] = 0;
            else if (m_md_spent[i] + 1 == md_limit[i]) begin
                m_md_busy[i] = 0;
                m_to[i] = 1;
            end else m_md_spent[i]++;
        end else if (ex_valid && ex_pc_sel) begin
            c = 7'b0010100;
        end else if (ex_valid && ex_md_op) begin
            c = 7'b1101011;
            m_md_busy[i] = 1;
            m_md_spent[i] = 0;
        end else if (uses_load) begin
            c = 7'b1100100;
            m_bubbles[i] = load_lat[i] - 1;
        end
        if (c[6] && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
    endtask

    task automatic cyc();
        logic [6:0] e;
        @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("stall%0d", i), 64'(got_stall[i]), 64'(m_cnt[i]));
            chk($sformatf("timeout%0d", i), 64'(got_to[i]), 64'(m_to[i]));
            model_step(i, e);
            chk($sformatf("ctrl%0d", i), 64'(got_ctrl[i]), 64'(e));
            chk($sformatf("md_start_twice%0d", i), 64'(got_ctrl[i][0] & prev_start[i]), 64'd0);
            prev_start[i] = got_ctrl[i][0];
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clr_in();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; ex_valid = 0;
        ex_rd = 0; ex_is_load = 0; ex_pc_sel = 0; ex_md_op = 0; md_done = 0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic used);
        ex_valid = 1; ex_is_load = 1; ex_rd = rd; id_rs1 = rs1; id_rs1_used = used;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b0;
        clr_in();
        model_reset();
        cyc(); cyc();
        sys_rst = 1'b1;
        cyc(); cyc();

        // Load-use hazard for one cycle: one bubble (LOAD_LAT=1) and three (LOAD_LAT=3).
        load_use(5'd5, 5'd5, 1'b1); cyc(); clr_in();
        repeat (4) cyc();
        chk("lu_stall_a", 64'(got_stall[0]), 64'd1);
        chk("lu_stall_b", 64'(got_stall[1]), 64'd3);

        // Writes to x0 and unused sources never stall.
        load_use(5'd0, 5'd0, 1'b1); cyc(); clr_in();
        load_use(5'd5, 5'd5, 1'b0); cyc(); clr_in();
        repeat (2) cyc();
        chk("nohz_stall_a", 64'(got_stall[0]), 64'd1);

        // Redirect wins over load-use.
        load_use(5'd7, 5'd7, 1'b1); ex_pc_sel = 1; cyc(); clr_in();
        repeat (2) cyc();
        chk("redir_stall_a", 64'(got_stall[0]), 64'd1);

        // Mul/div with md_done ten cycles after start; the short-timeout instance times out first.
        ex_valid = 1; ex_md_op = 1; cyc(); clr_in();
        repeat (9) cyc();
        md_done = 1; cyc(); md_done = 0;
        repeat (3) cyc();
        chk("md_stall_a", 64'(got_stall[0]), 64'd12);
        chk("md_stall_b", 64'(got_stall[1]), 64'd12);
        chk("md_to_a", 64'(got_to[0]), 64'd0);
        chk("md_to_b", 64'(got_to[1]), 64'd1);

        // Asynchronous reset while waiting on mul/div.
        ex_valid = 1; ex_md_op = 1; cyc(); clr_in();
        repeat (3) cyc();
        sys_rst = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ctrl%0d", i), 64'(got_ctrl[i]), 64'd0);
            chk($sformatf("rst_stall%0d", i), 64'(got_stall[i]), 64'd0);
            chk($sformatf("rst_to%0d", i), 64'(got_to[i]), 64'd0);
        end
        ex_valid = 1; ex_pc_sel = 1;
        cyc(); cyc();
        clr_in();
        sys_rst = 1'b1;
        cyc();
        load_use(5'd9, 5'd9, 1'b1); cyc(); clr_in();
        repeat (4) cyc();
        chk("post_rst_stall_a", 64'(got_stall[0]), 64'd1);
        chk("post_rst_stall_b", 64'(got_stall[1]), 64'd3);

        // Random traffic; the 4-bit counter on instance b saturates early.
        repeat (3000) begin
            ex_valid    = ($urandom_range(3) != 0);
            ex_rd       = 5'($urandom_range(3));
            id_rs1      = 5'($urandom_range(3));
            id_rs2      = 5'($urandom_range(3));
            id_rs1_used = 1'($urandom_range(1));
            id_rs2_used = 1'($urandom_range(1));
            ex_is_load  = 1'($urandom_range(1));
            ex_pc_sel   = ($urandom_range(99) < 15);
            ex_md_op    = ($urandom_range(99) < 8);
            md_done     = ($urandom_range(99) < 10);
            cyc();
        end
        clr_in();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
